us_frame_packer: RTL and testbench



---
 rtl/us_frame_packer.sv | 122 ++++++++++++
 tb/tb_us_frame_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/us_frame_packer.sv
// Captures one trigger-started frame of signed ADC samples, packs two per 32-bit word into a FIFO, serves host reads.
// Read data appears the cycle after an accepted rden; pushes into a full FIFO are dropped and latched in overflow.
module us_frame_packer #(
  parameter int SAMPLE_W  = 14,
  parameter int FRAME_LEN = 1024,
  parameter int FIFO_AW   = 9
) (
  input  logic                bus_clk,
  input  logic                bus_rst_n,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                trig,
  input  logic                user_r_read_32_open,
  input  logic                user_r_read_32_rden,
  output logic [31:0]         user_r_read_32_data,
  output logic                user_r_read_32_empty,
  output logic                user_r_read_32_eof,
  output logic                frame_busy,
  output logic                overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     smp_cnt;
  logic [15:0]          low_half;
  logic [15:0]          smp_ext;
  logic [31:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic [31:0]          rd_data;
  logic                 eof_q, ovf_q;
  logic                 open, accept, push_req, push, pop, full, last_smp;

  assign open     = user_r_read_32_open;
  assign smp_ext  = 16'($signed(adc_data));
  assign full     = (count == FULL_CNT);
  assign accept   = (state == CAPTURE) && adc_valid && open;
  assign push_req = accept && smp_cnt[0];
  assign push     = push_req && !full;
  assign pop      = open && user_r_read_32_rden && (count != '0);
  assign last_smp = accept && (smp_cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    if (!open) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (trig) state_nxt = CAPTURE;
        CAPTURE: if (last_smp) state_nxt = DRAIN;
        DRAIN:   if (count == '0) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counter and low half are held clear in IDLE, so every frame starts on an even sample.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state    <= IDLE;
      smp_cnt  <= '0;
      low_half <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        smp_cnt  <= '0;
        low_half <= '0;
      end else if (accept) begin
        smp_cnt <= smp_cnt + 1'b1;
        if (!smp_cnt[0]) low_half <= smp_ext;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      eof_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!open) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      eof_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      eof_q <= (state == DONE);
      if (push_req && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr] <= {smp_ext, low_half};
  end

  assign user_r_read_32_data  = rd_data;
  assign user_r_read_32_empty = (count == '0);
  assign user_r_read_32_eof   = eof_q;
  assign frame_busy           = (state == CAPTURE);
  assign overflow             = ovf_q;

endmodule

// File: tb/tb_us_frame_packer.sv
// Directed bench: instance a (FRAME_LEN 8, deep FIFO) and instance b (FRAME_LEN 12, 4-word FIFO) share stimulus.
module tb_us_frame_packer;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n;
  logic        adc_valid, trig, rden, open_a, open_b;
  logic [13:0] adc_data;
  logic [31:0] data_a, data_b;
  logic        empty_a, empty_b, eof_a, eof_b, busy_a, busy_b, ovf_a, ovf_b;

  int          total = 0;
  int          bad   = 0;
  int          n_rd  = 0;
  logic        sel   = 1'b0;
  logic [31:0] exp_q[$];

  always #5 bus_clk = ~bus_clk;

  us_frame_packer #(.SAMPLE_W(14), .FRAME_LEN(8), .FIFO_AW(4)) u_a (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .adc_valid(adc_valid), .adc_data(adc_data), .trig(trig),
    .user_r_read_32_open(open_a), .user_r_read_32_rden(rden),
    .user_r_read_32_data(data_a), .user_r_read_32_empty(empty_a),
    .user_r_read_32_eof(eof_a), .frame_busy(busy_a), .overflow(ovf_a)
  );

  us_frame_packer #(.SAMPLE_W(14), .FRAME_LEN(12), .FIFO_AW(2)) u_b (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .adc_valid(adc_valid), .adc_data(adc_data), .trig(trig),
    .user_r_read_32_open(open_b), .user_r_read_32_rden(rden),
    .user_r_read_32_data(data_b), .user_r_read_32_empty(empty_b),
    .user_r_read_32_eof(eof_b), .frame_busy(busy_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; a read accepted at this edge is checked against the next expected word.
  task automatic tick();
    logic        pp;
    logic [31:0] exp_w;
    pp = rden && !(sel ? empty_b : empty_a);
    @(posedge bus_clk);
    #1;
    if (pp) begin
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("rd_word", sel ? data_b : data_a, exp_w);
      n_rd++;
    end
  endtask

  task automatic push_sample(input logic [13:0] v);
    adc_valid = 1'b1;
    adc_data  = v;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic start_frame();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic drain_until_eof(input int lim);
    int i;
    i = 0;
    rden = 1'b1;
    while (i < lim && !(sel ? eof_b : eof_a)) begin
      tick();
      i++;
    end
    rden = 1'b0;
    check("eof", sel ? eof_b : eof_a, 1);
  endtask

  initial begin
    bus_rst_n = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    trig      = 1'b0;
    rden      = 1'b0;
    open_a    = 1'b0;
    open_b    = 1'b0;
    #12;
    check("rst_data",  data_a,  0);
    check("rst_empty", empty_a, 1);
    check("rst_eof",   eof_a,   0);
    check("rst_busy",  busy_a,  0);
    check("rst_ovf",   ovf_a,   0);
    check("rst_empty_b", empty_b, 1);
    bus_rst_n = 1'b1;
    tick();

    // pack order and sign extension
    open_a = 1'b1;
    start_frame();
    check("busy_cap", busy_a, 1);
    push_sample(14'h1FFF);
    check("empty_even", empty_a, 1);
    push_sample(14'h2000);
    check("empty_push", empty_a, 0);
    exp_q.push_back(32'hE000_1FFF);
    n_rd = 0;
    rden = 1'b1;
    tick();
    rden = 1'b0;
    check("n_rd_pack", n_rd, 1);
    open_a = 1'b0;
    tick();
    check("busy_drop", busy_a, 0);

    // full frame with continuous reads
    open_a = 1'b1;
    start_frame();
    exp_q.delete();
    exp_q.push_back(32'h0002_0001);
    exp_q.push_back(32'h0004_0003);
    exp_q.push_back(32'h0006_0005);
    exp_q.push_back(32'h0008_0007);
    n_rd = 0;
    rden = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_sample(14'(i));
      if (i == 7) check("busy_s7", busy_a, 1);
      if (i == 8) check("busy_s8", busy_a, 0);
    end
    drain_until_eof(20);
    check("n_rd_frame", n_rd, 4);
    check("empty_done", empty_a, 1);

    // gating: trig while closed, trig during capture
    open_a = 1'b0;
    tick();
    check("eof_clr", eof_a, 0);
    trig = 1'b1;
    for (int i = 0; i < 3; i++) push_sample(14'h0055);
    trig = 1'b0;
    check("closed_busy",  busy_a,  0);
    check("closed_empty", empty_a, 1);
    open_a = 1'b1;
    tick();
    check("open_no_trig", busy_a, 0);
    trig = 1'b1;
    tick();
    push_sample(14'h3FFF);
    push_sample(14'h0001);
    push_sample(14'h2000);
    push_sample(14'h1FFF);
    push_sample(14'h0000);
    push_sample(14'h0000);
    push_sample(14'h0010);
    check("trig_busy7", busy_a, 1);
    push_sample(14'h3FF0);
    check("trig_busy8", busy_a, 0);
    trig = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0001_FFFF);
    exp_q.push_back(32'h1FFF_E000);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'hFFF0_0010);
    n_rd = 0;
    drain_until_eof(20);
    check("n_rd_trig", n_rd, 4);

    // open drop mid-frame, then a clean restart
    open_a = 1'b0;
    tick();
    open_a = 1'b1;
    start_frame();
    push_sample(14'h0100);
    push_sample(14'h0200);
    push_sample(14'h0300);
    open_a = 1'b0;
    tick();
    check("drop_busy",  busy_a,  0);
    check("drop_empty", empty_a, 1);
    open_a = 1'b1;
    start_frame();
    push_sample(14'h0007);
    push_sample(14'h0008);
    exp_q.delete();
    exp_q.push_back(32'h0008_0007);
    n_rd = 0;
    rden = 1'b1;
    tick();
    tick();
    rden = 1'b0;
    check("n_rd_restart", n_rd, 1);
    open_a = 1'b0;
    tick();

    // overflow on the 4-word FIFO
    sel    = 1'b1;
    open_b = 1'b1;
    start_frame();
    for (int i = 1; i <= 12; i++) begin
      push_sample(14'(i));
      if (i == 9)  check("ovf_s9",  ovf_b, 0);
      if (i == 10) check("ovf_s10", ovf_b, 1);
    end
    check("ovf_busy",  busy_b,  0);
    check("ovf_empty", empty_b, 0);
    exp_q.delete();
    exp_q.push_back(32'h0002_0001);
    exp_q.push_back(32'h0004_0003);
    exp_q.push_back(32'h0006_0005);
    exp_q.push_back(32'h0008_0007);
    n_rd = 0;
    drain_until_eof(20);
    check("n_rd_ovf", n_rd, 4);
    check("ovf_sticky", ovf_b, 1);
    open_b = 1'b0;
    tick();
    check("ovf_clr",     ovf_b,   0);
    check("eof_clr_b",   eof_b,   0);
    check("empty_clr_b", empty_b, 1);
    sel = 1'b0;

    // asynchronous reset while draining
    open_a = 1'b1;
    start_frame();
    for (int i = 9; i <= 16; i++) push_sample(14'(i));
    check("drain_busy",  busy_a,  0);
    check("drain_empty", empty_a, 0);
    check("drain_eof",   eof_a,   0);
    #3;
    bus_rst_n = 1'b0;
    #1;
    check("arst_data",  data_a,  0);
    check("arst_empty", empty_a, 1);
    check("arst_busy",  busy_a,  0);
    check("arst_ovf",   ovf_a,   0);
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
